// File: rtl/cache_fill_arb.sv
// Fixed-priority block-fill arbiter: picks one missing cache, streams a block of
// WORDS reads to memory, writes the returned words back, then pulses tag_we/done.
module cache_fill_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int NUM_CH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          miss_req,
  input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_data_valid,
  input  logic [DATA_W-1:0]          mem_data,
  output logic [NUM_CH-1:0]          grant,
  output logic                       busy,
  output logic                       fill_we,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [DATA_W-1:0]          fill_data,
  output logic [NUM_CH-1:0]          tag_we,
  output logic [NUM_CH-1:0]          done
);

  localparam int WB = $clog2(WORDS);
  localparam int CW = WB + 1;
  localparam logic [CW-1:0]     WORDS_C   = CW'(WORDS);
  localparam logic [CW-1:0]     LAST_C    = CW'(WORDS - 1);
  // Words are 2 bytes, so a block spans 2*WORDS bytes.
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-CW){1'b1}}, {CW{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CW-1:0]       issue_q, issue_d;
  logic [CW-1:0]       recv_q, recv_d;
  logic                busy_q, busy_d;
  logic [NUM_CH-1:0]   tag_we_q, tag_we_d;
  logic [NUM_CH-1:0]   done_q, done_d;

  logic [NUM_CH-1:0]   pick;
  logic [ADDR_W-1:0]   pick_addr;
  logic                issuing;
  logic                accept;

  // Scan from the top down so the lowest-index requester is the last write and wins.
  always_comb begin
    pick      = '0;
    pick_addr = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (miss_req[c]) begin
        pick      = '0;
        pick[c]   = 1'b1;
        pick_addr = miss_addr[c*ADDR_W +: ADDR_W];
      end
    end
  end

  assign issuing   = (state_q == FILL) && (issue_q < WORDS_C);
  assign accept    = (state_q == FILL) && mem_data_valid && (recv_q < WORDS_C);

  assign mem_en    = issuing;
  assign mem_addr  = issuing ? (base_q + ADDR_W'({issue_q, 1'b0})) : '0;
  assign fill_we   = accept;
  assign fill_word = recv_q[WB-1:0];
  assign fill_data = mem_data;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    base_d  = base_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    unique case (state_q)
      IDLE: begin
        if (|miss_req) begin
          state_d = FILL;
          grant_d = pick;
          base_d  = pick_addr & BASE_MASK;
          issue_d = '0;
          recv_d  = '0;
        end
      end
      FILL: begin
        if (issuing) issue_d = issue_q + CW'(1);
        if (accept) begin
          recv_d = recv_q + CW'(1);
          if (recv_q == LAST_C) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // Registered outputs are derived from the next state so they align with it.
    busy_d   = (state_d != IDLE);
    tag_we_d = (state_d == DONE) ? grant_d : '0;
    done_d   = (state_d == DONE) ? grant_d : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      base_q   <= '0;
      issue_q  <= '0;
      recv_q   <= '0;
      busy_q   <= 1'b0;
      tag_we_q <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      base_q   <= base_d;
      issue_q  <= issue_d;
      recv_q   <= recv_d;
      busy_q   <= busy_d;
      tag_we_q <= tag_we_d;
      done_q   <= done_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign tag_we = tag_we_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cache_fill_arb.sv
// Scoreboard bench for cache_fill_arb: directed misses push expected issues, fills
// and done pulses; a negedge monitor pops and compares against a latency memory model.
`timescale 1ns/1ps
module tb_cache_fill_arb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int WORDS  = 8;
  localparam int NUM_CH = 2;
  localparam int LAT    = 4;   // dead cycles between an issue and its return
  localparam int GAP    = 2;   // dead cycles between returns in gap mode

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        miss_req;
  logic [NUM_CH*ADDR_W-1:0] miss_addr;
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_data_valid;
  logic [DATA_W-1:0]        mem_data;
  logic [NUM_CH-1:0]        grant;
  logic                     busy;
  logic                     fill_we;
  logic [2:0]               fill_word;
  logic [DATA_W-1:0]        fill_data;
  logic [NUM_CH-1:0]        tag_we;
  logic [NUM_CH-1:0]        done;

  cache_fill_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .grant(grant), .busy(busy), .fill_we(fill_we),
    .fill_word(fill_word), .fill_data(fill_data), .tag_we(tag_we), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NUM_CH-1:0] grant; logic [ADDR_W-1:0] addr; } iss_t;
  typedef struct { logic [2:0] word; logic [DATA_W-1:0] data; } fill_t;
  typedef struct { logic [ADDR_W-1:0] addr; int cyc; } mreq_t;

  iss_t              exp_iss_q[$];
  fill_t             exp_fill_q[$];
  logic [NUM_CH-1:0] exp_done_q[$];
  mreq_t             mem_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h0F0F;
  endfunction

  // Cycle counter and memory model
  int cyc = 0;
  bit gap_mode = 0;
  bit extra_after_last = 0;
  bit mem_flush = 0;
  int stray_req = 0;
  int stray_done = 0;
  int last_ret = -100;
  bit extra_pend = 0;
  mreq_t r;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    mem_data_valid = 1'b0;
    mem_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_data_valid = 1'b0;
      mem_data       = '0;
      if (mem_flush) begin
        mem_q.delete();
        extra_pend = 0;
      end else if (mem_q.size() > 0 && cyc >= mem_q[0].cyc + LAT + 1 &&
                   (!gap_mode || cyc >= last_ret + GAP + 1)) begin
        r = mem_q.pop_front();
        mem_data_valid = 1'b1;
        mem_data       = mem_word(r.addr);
        last_ret       = cyc;
        if (mem_q.size() == 0 && extra_after_last) extra_pend = 1;
      end else if (extra_pend || stray_req != stray_done) begin
        mem_data_valid = 1'b1;
        mem_data       = 16'hBAD0;
        extra_pend     = 0;
        stray_done     = stray_req;
      end
    end
  end

  // Monitor / scoreboard
  int busy_cycles = 0;
  int fill_total = 0;
  int done_cnt = 0;
  int words_seen = 0;
  int first_issue_cyc = -1;
  logic [ADDR_W-1:0] last_addr = '0;
  bit mem_en_prev = 0;
  iss_t e;
  fill_t f;
  logic [NUM_CH-1:0] d;

  initial forever begin
    @(negedge clk);
    if (!rst_n) words_seen = 0;
    if (busy) busy_cycles++;
    if (mem_en) begin
      if (!mem_en_prev) first_issue_cyc = cyc;
      last_addr = mem_addr;
      mem_q.push_back('{addr: mem_addr, cyc: cyc});
      if (exp_iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got mem_addr 0x%0h expected no issue", mem_addr);
      end else begin
        e = exp_iss_q.pop_front();
        check("mem_addr", mem_addr, e.addr);
        check("grant_on_issue", grant, e.grant);
      end
    end
    mem_en_prev = mem_en;
    if (fill_we) begin
      fill_total++;
      words_seen++;
      if (exp_fill_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fill_we: got word %0d expected no write", fill_word);
      end else begin
        f = exp_fill_q.pop_front();
        check("fill_word", fill_word, f.word);
        check("fill_data", fill_data, f.data);
      end
    end
    if (done != '0 || tag_we != '0) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done %b tag_we %b expected none", done, tag_we);
      end else begin
        d = exp_done_q.pop_front();
        check("done", done, d);
        check("tag_we", tag_we, d);
        check("grant_at_done", grant, d);
        check("words_before_done", words_seen, WORDS);
      end
      words_seen = 0;
      done_cnt++;
    end
  end

  // Stimulus helpers
  task automatic expect_fill(input int ch, input logic [ADDR_W-1:0] base);
    logic [NUM_CH-1:0] g;
    logic [ADDR_W-1:0] a;
    g = '0;
    g[ch] = 1'b1;
    for (int w = 0; w < WORDS; w++) begin
      a = base + ADDR_W'(2 * w);
      exp_iss_q.push_back('{grant: g, addr: a});
      exp_fill_q.push_back('{word: 3'(w), data: mem_word(a)});
    end
    exp_done_q.push_back(g);
  endtask

  // Returns at negedge+1 of the done cycle so the requester can still drop miss_req.
  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_mem_en"},    mem_en,    0);
    check({name, "_mem_addr"},  mem_addr,  0);
    check({name, "_fill_we"},   fill_we,   0);
    check({name, "_fill_word"}, fill_word, 0);
    check({name, "_tag_we"},    tag_we,    0);
    check({name, "_done"},      done,      0);
    check({name, "_busy"},      busy,      0);
    check({name, "_grant"},     grant,     0);
  endtask

  int start_cyc;
  int b0;
  int f0;
  int n;

  initial begin
    rst_n     = 1'b0;
    miss_req  = '0;
    miss_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single ch0 miss at 0x1234, pipelined memory
    expect_fill(0, 16'h1230);
    b0 = busy_cycles;
    start_cyc = cyc;
    miss_addr = {16'h0000, 16'h1234};
    miss_req  = 2'b01;
    wait_done(1, "single");
    miss_req = '0;
    check("first_issue_latency", first_issue_cyc, start_cyc + 1);
    check("busy_cycles_single", busy_cycles - b0, 1 + WORDS + LAT + 1);
    check("last_addr_single", last_addr, 16'h123E);
    @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);

    // Simultaneous requests: ch0 first, then ch1
    expect_fill(0, 16'h0040);
    expect_fill(1, 16'h8000);
    miss_addr = {16'h8006, 16'h0040};
    miss_req  = 2'b11;
    wait_done(2, "dual_ch0");
    miss_req[0] = 1'b0;
    wait_done(3, "dual_ch1");
    miss_req[1] = 1'b0;
    @(negedge clk);

    // Gapped returns plus one extra valid landing in DONE
    gap_mode = 1;
    extra_after_last = 1;
    expect_fill(1, 16'h2460);
    @(posedge clk);
    #2;
    b0 = busy_cycles;
    miss_addr = {16'h246A, 16'h0000};
    miss_req  = 2'b10;
    wait_done(4, "gap");
    miss_req = '0;
    check("busy_cycles_gap", busy_cycles - b0, 1 + (WORDS - 1) * (GAP + 1) + LAT + 1 + 1);
    repeat (3) @(negedge clk);
    gap_mode = 0;
    extra_after_last = 0;

    // Stray valid while idle
    f0 = fill_total;
    stray_req++;
    repeat (4) @(negedge clk);
    #1;
    check("stray_no_fill", fill_total, f0);
    check("stray_busy", busy, 0);
    check("stray_grant", grant, 0);

    // Top-of-space block: issue must stay inside 0xFFF0..0xFFFE
    expect_fill(0, 16'hFFF0);
    @(posedge clk);
    #2;
    miss_addr = {16'h0000, 16'hFFF7};
    miss_req  = 2'b01;
    wait_done(5, "wrap");
    miss_req = '0;
    check("last_addr_wrap", last_addr, 16'hFFFE);
    repeat (2) @(negedge clk);

    // Reset after the fifth returned word; fill restarts from the base
    expect_fill(1, 16'h3000);
    f0 = fill_total;
    @(posedge clk);
    #2;
    miss_addr = {16'h300C, 16'h0000};
    miss_req  = 2'b10;
    n = 0;
    while (fill_total < f0 + 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("words_before_reset", fill_total - f0, 5);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    mem_flush = 1;
    #1;
    check_all_zero("midfill_reset");
    exp_iss_q.delete();
    exp_fill_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("reset_hold_tag_we", tag_we, 0);
    expect_fill(1, 16'h3000);
    mem_flush = 0;
    rst_n     = 1'b1;
    wait_done(6, "restart");
    miss_req = '0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_iss_q.size() + exp_fill_q.size() + exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cache_fill_arb.md
CACHE_FILL_ARB -- requirements
Module: cache_fill_arb

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- DATA_W, 16, memory/data word width.
- ADDR_W, 16, byte address width.
- WORDS, 8, words per cache block; power of two, >=2.
- NUM_CH, 2, number of requesting caches; channel 0 is the highest priority.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- miss_req, in, NUM_CH, per-channel miss level, held until done.
- miss_addr, in, NUM_CH*ADDR_W, miss byte address; channel c is at [c*ADDR_W +: ADDR_W].
- mem_en, out, 1, memory read issue strobe.
- mem_addr, out, ADDR_W, byte address being issued.
- mem_data_valid, in, 1, read data return strobe.
- mem_data, in, DATA_W, returned word.
- grant, out, NUM_CH, one-hot channel being serviced; zero when idle.
- busy, out, 1, fill in progress (FILL or DONE state).
- fill_we, out, 1, write fill_data into the granted channel's data array.
- fill_word, out, log2(WORDS), word index for fill_we.
- fill_data, out, DATA_W, equals mem_data.
- tag_we, out, NUM_CH, one-cycle tag/valid write for the granted channel.
- done, out, NUM_CH, one-cycle fill-complete pulse per channel.

Function
REQ-003 The state machine SHALL have three states: IDLE, FILL and DONE.
REQ-004 In IDLE with any miss_req bit set, the FSM SHALL latch the lowest-index requesting channel into grant, latch its block base, and enter FILL on the next edge.
- Block base = miss_addr with the low log2(WORDS)+1 bits cleared.
REQ-005 In FILL the FSM SHALL issue one read per cycle while issue count < WORDS.
- mem_en = 1 and mem_addr = base + 2*issue_count.
- The first issue occurs in the first FILL cycle, i.e. 1 cycle after miss_req is sampled in IDLE.
REQ-006 After WORDS issues, mem_en SHALL be 0 for the remainder of the fill.
REQ-007 In FILL, each mem_data_valid SHALL assert fill_we in the same cycle, with fill_word = receive count and fill_data = mem_data, then increment the receive count.
- Returns are in order; memory latency is arbitrary, and gaps between returns are allowed.
REQ-008 On the valid that carries word WORDS-1, the FSM SHALL enter DONE.
REQ-009 In DONE the FSM SHALL assert tag_we and done for the granted channel for exactly one cycle, then return to IDLE.
- grant remains valid through DONE.
REQ-010 mem_data_valid outside FILL, or beyond WORDS returns, SHALL be ignored: no fill_we and no counter change.
REQ-011 Issue and receive counters SHALL be log2(WORDS)+1 bits wide.
- Address arithmetic wraps modulo 2^ADDR_W.
REQ-012 Requests arriving while busy SHALL wait; they are arbitrated only in IDLE.
REQ-013 Simultaneous requests SHALL be serviced in ascending channel order, one full block each.
REQ-014 A requester SHALL deassert miss_req by the edge ending its done cycle.
- A miss_req dropped mid-fill SHALL NOT abort the fill; done still pulses.
REQ-015 grant, busy, tag_we and done SHALL be driven from registers.
- mem_en, mem_addr, fill_we, fill_word and fill_data MAY be decoded from state plus mem_data_valid.

Reset
REQ-016 rst_n low SHALL force IDLE and clear the counters, grant and base asynchronously.
- All outputs become 0: mem_en, fill_we, tag_we, done, busy, grant, mem_addr, fill_word; fill_data follows mem_data but is qualified by fill_we = 0.
REQ-017 Reset asserted mid-fill SHALL abandon the fill with no tag_we.
- After release, a still-asserted miss_req SHALL restart the fill from word 0.

Verification
REQ-018 The bench SHALL cover, with WORDS=8, NUM_CH=2 and a 4-cycle-latency pipelined memory model:
- Single miss, ch0, addr 0x1234 -> mem_addr 0x1230, 0x1232 ... 0x123E on 8 consecutive cycles; fill_word 0-7 with matching data; then tag_we=2'b01 and done=2'b01 for one cycle; busy for 1+8+4+1 cycles.
- miss_req=2'b11 at once, ch0 0x0040, ch1 0x8006 -> full ch0 fill (base 0x0040) first, then ch1 (base 0x8000); grant 01 then 10; no overlap.
- Memory with 2-cycle gaps between returns -> fill_word strictly 0..7, one fill_we per valid, DONE only after the eighth valid.
- Stray mem_data_valid in IDLE and a ninth valid -> no fill_we, no state change.
- rst_n low after the fifth returned word -> all outputs 0 immediately; no tag_we; after release with miss_req still high, issue restarts at the base address.
- Base 0xFFF0 -> last mem_addr 0xFFFE; no carry into other bits; wrap check.
